pipe_controller: RTL and testbench

PIPE_CONTROLLER -- requirements
Module: pipe_controller

---
 rtl/pipe_controller_pkg.sv | 69 ++++++
 rtl/pipe_controller_if.sv | 44 ++++
 rtl/pipe_controller_main_dec.sv | 75 +++++++
 rtl/pipe_controller.sv | 89 ++++++++
 tb/tb_pipe_controller.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/pipe_controller_pkg.sv
// pipe_controller_pkg
//   Shared definitions for the pipelined MIPS-subset controller: opcode and
//   funct constants, ALUControl / PCSrc / ALUSrc encodings, and the control
//   bundle carried by each of the E, M and W pipeline stages.
package pipe_controller_pkg;

    // Opcodes (InstrD[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type funct codes (InstrD[5:0])
    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'b00,
        PC_BRANCH = 2'b01,
        PC_JUMP   = 2'b10
    } pc_src_e;

    localparam logic [1:0] ALUSRC_REG = 2'b00;
    localparam logic [1:0] ALUSRC_IMM = 2'b01;

    // E-stage bundle: everything the decoder produces for the datapath.
    typedef struct packed {
        logic      valid;
        logic      reg_write;
        logic      mem_to_reg;
        logic      mem_write;
        logic      reg_dst;
        logic [1:0] alu_src;
        alu_ctrl_e alu_ctrl;
    } ctrl_e_t;

    // M-stage bundle: ALU-side controls have been consumed in E.
    typedef struct packed {
        logic valid;
        logic reg_write;
        logic mem_to_reg;
        logic mem_write;
    } ctrl_m_t;

    // W-stage bundle: only writeback controls remain.
    typedef struct packed {
        logic valid;
        logic reg_write;
        logic mem_to_reg;
    } ctrl_w_t;

    localparam ctrl_e_t CTRL_E_BUBBLE = ctrl_e_t'('0);
    localparam ctrl_m_t CTRL_M_BUBBLE = ctrl_m_t'('0);
    localparam ctrl_w_t CTRL_W_BUBBLE = ctrl_w_t'('0);

endpackage

// File: rtl/pipe_controller_if.sv
// pipe_controller_if
//   Bundles the decode inputs from the datapath and all stage control outputs
//   of the controller.
//   slave  : controller side (Opcode/Funct/EqualD/FlushE in, controls out)
//   master : datapath/hazard side (drives decode inputs, observes controls)
interface pipe_controller_if #(
    parameter int CNTW = 32
);
    logic [5:0]      Opcode;
    logic [5:0]      Funct;
    logic            EqualD;
    logic            FlushE;
    logic [1:0]      PCSrcD;
    logic            BranchD;
    logic            JumpD;
    logic            IllegalD;
    logic            RegDstE;
    logic [1:0]      ALUSrcE;
    logic [2:0]      ALUControlE;
    logic            RegWriteE;
    logic            MemToRegE;
    logic            RegWriteM;
    logic            MemToRegM;
    logic            MemWriteM;
    logic            RegWriteW;
    logic            MemToRegW;
    logic [CNTW-1:0] RetiredW;

    modport slave (
        input  Opcode, Funct, EqualD, FlushE,
        output PCSrcD, BranchD, JumpD, IllegalD,
               RegDstE, ALUSrcE, ALUControlE, RegWriteE, MemToRegE,
               RegWriteM, MemToRegM, MemWriteM,
               RegWriteW, MemToRegW, RetiredW
    );

    modport master (
        output Opcode, Funct, EqualD, FlushE,
        input  PCSrcD, BranchD, JumpD, IllegalD,
               RegDstE, ALUSrcE, ALUControlE, RegWriteE, MemToRegE,
               RegWriteM, MemToRegM, MemWriteM,
               RegWriteW, MemToRegW, RetiredW
    );
endinterface

// File: rtl/pipe_controller_main_dec.sv
// main_dec
//   Combinational instruction decoder.
//   opcode, funct : instruction fields from the decode stage
//   ctrl          : E-stage control bundle (bubble for unknown instructions)
//   branch, jump  : decode-stage control-flow flags
//   illegal       : opcode or R-type funct not recognised
module main_dec
    import pipe_controller_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output ctrl_e_t    ctrl,
    output logic       branch,
    output logic       jump,
    output logic       illegal
);

    always_comb begin
        ctrl    = CTRL_E_BUBBLE;
        branch  = 1'b0;
        jump    = 1'b0;
        illegal = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                ctrl.valid     = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
                ctrl.alu_src   = ALUSRC_REG;
                case (funct)
                    F_ADD:   ctrl.alu_ctrl = ALU_ADD;
                    F_SUB:   ctrl.alu_ctrl = ALU_SUB;
                    F_AND:   ctrl.alu_ctrl = ALU_AND;
                    F_OR:    ctrl.alu_ctrl = ALU_OR;
                    F_SLT:   ctrl.alu_ctrl = ALU_SLT;
                    default: begin
                        // Unknown funct degrades to a nop, not a partial R-type.
                        ctrl    = CTRL_E_BUBBLE;
                        illegal = 1'b1;
                    end
                endcase
            end
            OP_LW: begin
                ctrl.valid      = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.alu_src    = ALUSRC_IMM;
                ctrl.alu_ctrl   = ALU_ADD;
            end
            OP_SW: begin
                ctrl.valid     = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = ALUSRC_IMM;
                ctrl.alu_ctrl  = ALU_ADD;
            end
            OP_ADDI: begin
                ctrl.valid     = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = ALUSRC_IMM;
                ctrl.alu_ctrl  = ALU_ADD;
            end
            OP_BEQ: begin
                // Still a valid instruction (it retires) but writes nothing.
                ctrl.valid    = 1'b1;
                ctrl.alu_ctrl = ALU_SUB;
                branch        = 1'b1;
            end
            OP_J: begin
                ctrl.valid = 1'b1;
                jump       = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/pipe_controller.sv
// pipe_controller
//   Control path of a 5-stage MIPS-subset pipeline. Decodes in D, then carries
//   a valid bit and control bundle through E, M and W, advancing every cycle,
//   and counts instructions that reach W.
//   clk   : single clock, rising edge
//   reset : synchronous, active high; clears E/M/W and the retire counter
//   bus   : pipe_controller_if slave (decode inputs, FlushE, stage controls)
module pipe_controller
    import pipe_controller_pkg::*;
#(
    parameter int CNTW = 32
) (
    input  logic              clk,
    input  logic              reset,
    pipe_controller_if.slave  bus
);

    ctrl_e_t         dec_ctrl;
    logic            dec_branch;
    logic            dec_jump;
    logic            dec_illegal;

    ctrl_e_t         e_d, e_q;
    ctrl_m_t         m_d, m_q;
    ctrl_w_t         w_d, w_q;
    logic [CNTW-1:0] retired_d, retired_q;

    main_dec u_main_dec (
        .opcode  (bus.Opcode),
        .funct   (bus.Funct),
        .ctrl    (dec_ctrl),
        .branch  (dec_branch),
        .jump    (dec_jump),
        .illegal (dec_illegal)
    );

    // Decode-stage outputs are purely combinational, reset or not.
    always_comb begin
        bus.PCSrcD = PC_PLUS4;
        if (dec_jump)
            bus.PCSrcD = PC_JUMP;
        else if (dec_branch && bus.EqualD)
            bus.PCSrcD = PC_BRANCH;
    end

    assign bus.BranchD  = dec_branch;
    assign bus.JumpD    = dec_jump;
    assign bus.IllegalD = dec_illegal;

    always_comb begin
        e_d = bus.FlushE ? CTRL_E_BUBBLE : dec_ctrl;
        m_d = '{valid:      e_q.valid,
                reg_write:  e_q.reg_write,
                mem_to_reg: e_q.mem_to_reg,
                mem_write:  e_q.mem_write};
        w_d = '{valid:      m_q.valid,
                reg_write:  m_q.reg_write,
                mem_to_reg: m_q.mem_to_reg};
        // Counts the instruction landing in W on this edge, not the one leaving.
        retired_d = retired_q + CNTW'(w_d.valid);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_q       <= CTRL_E_BUBBLE;
            m_q       <= CTRL_M_BUBBLE;
            w_q       <= CTRL_W_BUBBLE;
            retired_q <= '0;
        end else begin
            e_q       <= e_d;
            m_q       <= m_d;
            w_q       <= w_d;
            retired_q <= retired_d;
        end
    end

    assign bus.RegDstE     = e_q.reg_dst;
    assign bus.ALUSrcE     = e_q.alu_src;
    assign bus.ALUControlE = e_q.alu_ctrl;
    assign bus.RegWriteE   = e_q.reg_write;
    assign bus.MemToRegE   = e_q.mem_to_reg;
    assign bus.RegWriteM   = m_q.reg_write;
    assign bus.MemToRegM   = m_q.mem_to_reg;
    assign bus.MemWriteM   = m_q.mem_write;
    assign bus.RegWriteW   = w_q.reg_write;
    assign bus.MemToRegW   = w_q.mem_to_reg;
    assign bus.RetiredW    = retired_q;

endmodule

// File: tb/tb_pipe_controller.sv
// tb_pipe_controller
//   Drives directed and random instruction streams into pipe_controller and
//   compares every output against a reference built from a per-cycle log of
//   what each instruction should carry: a stage output at cycle t is simply
//   the log entry from t-1 (E), t-2 (M) or t-3 (W), zeroed if a reset edge
//   happened in between.
module tb_pipe_controller;

    localparam int CNTW = 4;
    localparam int NCYC = 700;

    localparam logic [5:0] IDLE = 6'b111111;  // unlisted opcode -> nop

    typedef struct packed {
        logic       valid;
        logic       rw;
        logic       m2r;
        logic       mw;
        logic       rdst;
        logic [1:0] asrc;
        logic [2:0] actl;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    pipe_controller_if #(.CNTW(CNTW)) bus ();

    pipe_controller #(.CNTW(CNTW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t issued [NCYC];
    logic rst_h  [NCYC];
    int   tests   = 0;
    int   fails   = 0;
    int   cyc     = 0;
    int   exp_ret = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
        end
    endtask

    // What an instruction means, written as a table of instruction kinds.
    function automatic exp_t ref_dec(input logic [5:0] op, input logic [5:0] fn,
                                     output logic br, output logic jp, output logic ill);
        exp_t r;
        r = '0; br = 1'b0; jp = 1'b0; ill = 1'b0;
        if (op == 6'b000000) begin
            if      (fn == 6'b100000) r = {5'b11001, 2'b00, 3'b010};  // add
            else if (fn == 6'b100010) r = {5'b11001, 2'b00, 3'b110};  // sub
            else if (fn == 6'b100100) r = {5'b11001, 2'b00, 3'b000};  // and
            else if (fn == 6'b100101) r = {5'b11001, 2'b00, 3'b001};  // or
            else if (fn == 6'b101010) r = {5'b11001, 2'b00, 3'b111};  // slt
            else ill = 1'b1;
        end
        else if (op == 6'b100011) r = {5'b11100, 2'b01, 3'b010};      // lw
        else if (op == 6'b101011) r = {5'b10010, 2'b01, 3'b010};      // sw
        else if (op == 6'b001000) r = {5'b11000, 2'b01, 3'b010};      // addi
        else if (op == 6'b000100) begin r = {5'b10000, 2'b00, 3'b110}; br = 1'b1; end
        else if (op == 6'b000010) begin r = {5'b10000, 2'b00, 3'b000}; jp = 1'b1; end
        else ill = 1'b1;
        return r;
    endfunction

    function automatic exp_t logged(input int i);
        return (i < 0) ? exp_t'('0) : issued[i];
    endfunction

    function automatic logic was_rst(input int i);
        return (i < 0) ? 1'b1 : rst_h[i];
    endfunction

    task automatic step(input logic [5:0] op, input logic [5:0] fn,
                        input logic eq, input logic fl, input logic rs);
        exp_t e, m, w, d;
        logic br, jp, ill;
        logic [1:0] pcs;
        if (cyc >= NCYC) begin
            chk("cycle_budget", 32'(cyc), 32'(NCYC - 1));
            $display("[TB] %0d tests run, %0d failed", tests, fails);
            $finish;
        end
        @(negedge clk);
        if (cyc >= 1) begin
            e = logged(cyc - 1);
            m = was_rst(cyc - 1) ? exp_t'('0) : logged(cyc - 2);
            w = (was_rst(cyc - 1) || was_rst(cyc - 2)) ? exp_t'('0) : logged(cyc - 3);
            exp_ret = was_rst(cyc - 1) ? 0 : (exp_ret + int'(w.valid)) % (1 << CNTW);
            chk("RegDstE",     32'(bus.RegDstE),     32'(e.rdst));
            chk("ALUSrcE",     32'(bus.ALUSrcE),     32'(e.asrc));
            chk("ALUControlE", 32'(bus.ALUControlE), 32'(e.actl));
            chk("RegWriteE",   32'(bus.RegWriteE),   32'(e.rw));
            chk("MemToRegE",   32'(bus.MemToRegE),   32'(e.m2r));
            chk("RegWriteM",   32'(bus.RegWriteM),   32'(m.rw));
            chk("MemToRegM",   32'(bus.MemToRegM),   32'(m.m2r));
            chk("MemWriteM",   32'(bus.MemWriteM),   32'(m.mw));
            chk("RegWriteW",   32'(bus.RegWriteW),   32'(w.rw));
            chk("MemToRegW",   32'(bus.MemToRegW),   32'(w.m2r));
            chk("RetiredW",    32'(bus.RetiredW),    32'(exp_ret));
        end
        bus.Opcode = op;
        bus.Funct  = fn;
        bus.EqualD = eq;
        bus.FlushE = fl;
        reset      = rs;
        #1;
        d   = ref_dec(op, fn, br, jp, ill);
        pcs = jp ? 2'b10 : ((br && eq) ? 2'b01 : 2'b00);
        chk("PCSrcD",   32'(bus.PCSrcD),   32'(pcs));
        chk("BranchD",  32'(bus.BranchD),  32'(br));
        chk("JumpD",    32'(bus.JumpD),    32'(jp));
        chk("IllegalD", 32'(bus.IllegalD), 32'(ill));
        issued[cyc] = (rs || fl) ? exp_t'('0) : d;
        rst_h[cyc]  = rs;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(IDLE, 6'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [5:0] op, fn;
        logic [5:0] fns [5];
        logic [5:0] ops [5];
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        ops = '{6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
        bus.Opcode = IDLE;
        bus.Funct  = 6'd0;
        bus.EqualD = 1'b0;
        bus.FlushE = 1'b0;

        // Reset, then a lone lw travelling to W.
        for (int i = 0; i < 3; i++) step(IDLE, 6'd0, 1'b0, 1'b0, 1'b1);
        step(6'b100011, 6'd0, 1'b0, 1'b0, 1'b0);
        idle(4);

        // R-type functs, including an illegal one.
        step(6'b000000, 6'b101010, 1'b0, 1'b0, 1'b0);
        step(6'b000000, 6'b111111, 1'b0, 1'b0, 1'b0);
        step(6'b000000, 6'b100000, 1'b0, 1'b0, 1'b0);
        step(6'b000000, 6'b100010, 1'b0, 1'b0, 1'b0);
        step(6'b000000, 6'b100100, 1'b0, 1'b0, 1'b0);
        step(6'b000000, 6'b100101, 1'b0, 1'b0, 1'b0);

        // Control flow: beq taken / not taken, j with either EqualD.
        step(6'b000100, 6'd0, 1'b1, 1'b0, 1'b0);
        step(6'b000100, 6'd0, 1'b0, 1'b0, 1'b0);
        step(6'b000010, 6'd0, 1'b0, 1'b0, 1'b0);
        step(6'b000010, 6'd0, 1'b1, 1'b0, 1'b0);

        // sw then a flushed add.
        step(6'b101011, 6'd0, 1'b0, 1'b0, 1'b0);
        step(6'b000000, 6'b100000, 1'b0, 1'b1, 1'b0);
        idle(4);

        // Reset while lw sits in M.
        step(6'b100011, 6'd0, 1'b0, 1'b0, 1'b0);
        idle(1);
        step(IDLE, 6'd0, 1'b0, 1'b0, 1'b1);
        idle(3);

        // Reset together with FlushE and an incoming lw.
        step(6'b100011, 6'd0, 1'b0, 1'b1, 1'b1);
        idle(3);

        // Counter wrap: 16 valid instructions from a cleared counter.
        step(IDLE, 6'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) step(6'b001000, 6'd0, 1'b0, 1'b0, 1'b0);
        idle(4);

        // Random traffic with occasional flushes and resets.
        for (int i = 0; i < 500; i++) begin
            case ($urandom_range(0, 3))
                0: begin op = 6'b000000; fn = fns[$urandom_range(0, 4)]; end
                1: begin op = 6'b000000; fn = 6'($urandom); end
                2: begin op = ops[$urandom_range(0, 4)]; fn = 6'($urandom); end
                default: begin op = 6'($urandom); fn = 6'($urandom); end
            endcase
            step(op, fn, 1'($urandom), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 39) == 0));
        end
        idle(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
